apu_song_sequencer: RTL and testbench
=====================================

// Module: apu_song_sequencer
// PURPOSE
//  Frame-synchronous music sequencer for the audio_processing_unit.
//  - Fetches 16-bit event words from an external synchronous song ROM.
//  - Issues channel register writes to the APU over a valid/ready port.
//  - Paces playback on the APU frame pulse.
//  - Sits between the song ROM and the APU register port; owns all APU
//    channel configuration while playing.
// PARAMETERS
//  ADDR_WIDTH      10  song ROM address width; PC wraps 2^ADDR_WIDTH-1 -> 0
//  WATCHDOG_LIMIT  64  max events without a WAIT (only with APU_SEQ_WATCHDOG_EN)
// PORTS
//  i_clk          in   1           system clock, single clock domain
//  i_rst_n        in   1           asynchronous reset, active-low
//  i_start        in   1           pulse: restart song from address 0
//  i_stop         in   1           pulse: halt playback
//  i_frame_pulse  in   1           1-cycle APU frame tick
//  o_rom_addr     out  ADDR_WIDTH  song ROM address; ROM read latency = 1 cycle
//  i_rom_data     in   16          song ROM data for previous cycle's address
//  o_wr_valid     out  1           register write request
//  i_wr_ready     in   1           APU accepts write when valid & ready
//  o_wr_channel   out  2           target channel 0-3
//  o_wr_reg       out  4           target register index
//  o_wr_data      out  8           register value
//  o_playing      out  1           high in any state except IDLE
//  o_error        out  1           watchdog trip, sticky until i_start (macro only)
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//  - All outputs 0; PC=0; state IDLE; wait counter 0.
//  Event word i_rom_data[15:14]:
//  - 00 WRITE: ch=[13:12], reg=[11:8], val=[7:0].
//  - 01 WAIT: n=[7:0] frames.
//  - 10 LOOP: PC<=[ADDR_WIDTH-1:0].
//  - 11 END.
//  State machine (IDLE, FETCH, DECODE, WRITE, WAIT):
//  - IDLE: i_start -> PC<=0, FETCH.
//  - FETCH: drive o_rom_addr=PC -> DECODE.
//  - DECODE: sample i_rom_data:
//    - WRITE -> load o_wr_* and set o_wr_valid -> WRITE.
//    - WAIT n=0 -> PC+1, FETCH; n>0 -> cnt<=n, PC+1 -> WAIT.
//    - LOOP -> PC<=target -> FETCH.
//    - END -> IDLE; PC unchanged.
//  - WRITE: hold o_wr_* stable while o_wr_valid=1 & !i_wr_ready.
//    - On handshake: o_wr_valid<=0, PC+1 -> FETCH.
//  - WAIT: each i_frame_pulse decrements cnt; at cnt==1 & pulse -> FETCH.
//    - Pulses are counted only in WAIT; a pulse in the cycle WAIT is entered
//      is ignored.
//  Latency:
//  - i_start sampled at cycle 0 -> FETCH at 1 -> DECODE at 2 -> o_wr_valid at 3.
//  - Back-to-back WRITEs with ready tied high: one write every 3 cycles.
//  Control rules:
//  - i_stop in any non-IDLE state -> IDLE next cycle, except in WRITE with
//    valid pending: the stop is latched and taken after the handshake
//    (valid never drops unaccepted).
//  - i_start while playing: restart from PC=0; same deferral rule in WRITE.
//  - i_start and i_stop in the same cycle: stop wins.
//  - PC increment wraps at 2^ADDR_WIDTH-1.
//  - Async reset mid-write drops o_wr_valid immediately (only legal drop).
// CONFIGURATION
//  APU_SEQ_WATCHDOG_EN defined:
//  - A counter counts DECODEd events; it is cleared in WAIT and IDLE.
//  - Reaching WATCHDOG_LIMIT (e.g. LOOP-to-self) -> IDLE, o_error<=1.
//  - o_error cleared by i_start or reset.
//  APU_SEQ_WATCHDOG_EN undefined:
//  - No counter; o_error tied 0.
//  - A tight LOOP spins until i_stop.
// TESTING
//  - Reset release, idle: all outputs 0, o_rom_addr=0, no writes for 100 cycles.
//  - ROM{0:0x1A3C, 1:0xC000}, start, ready=1 -> one write ch1 reg0xA data0x3C
//    at cycle 3; then IDLE, o_playing=0.
//  - ROM{0:WRITE, 1:0x4003 WAIT3, 2:WRITE}: second write only after the 3rd
//    frame pulse seen in WAIT; pulses during FETCH are not counted.
//  - Hold i_wr_ready=0 for 10 cycles with i_stop pulsed at cycle 2 ->
//    o_wr_* stable; IDLE right after the handshake.
//  - ROM{0:0x8000 LOOP0}, macro on, LIMIT=64 -> o_error=1 after 64 events;
//    macro off -> o_playing stays 1 until i_stop.
//  - PC wrap: ROM fully WAIT0 with 0x3FF=WRITE -> next fetch address 0x000.

Source files
------------

// File: rtl/apu_song_sequencer_if.sv
// Sequencer-facing bundle: song control, song ROM port and APU register-write port.
// The sequencer uses the master modport; the surrounding system uses slave.
interface apu_song_sequencer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  stop;
  logic                  frame_pulse;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [1:0]            wr_channel;
  logic [3:0]            wr_reg;
  logic [7:0]            wr_data;
  logic                  playing;
  logic                  error;

  modport master (
    input  start, stop, frame_pulse, rom_data, wr_ready,
    output rom_addr, wr_valid, wr_channel, wr_reg, wr_data, playing, error
  );

  modport slave (
    output start, stop, frame_pulse, rom_data, wr_ready,
    input  rom_addr, wr_valid, wr_channel, wr_reg, wr_data, playing, error
  );
endinterface

// File: rtl/apu_song_sequencer.sv
// Frame-paced song sequencer: walks event words in the song ROM and issues APU register writes.
// Optional event watchdog is built in when APU_SEQ_WATCHDOG_EN is defined.
module apu_song_sequencer #(
  parameter int ADDR_WIDTH = 10
`ifdef APU_SEQ_WATCHDOG_EN
  , parameter int WATCHDOG_LIMIT = 64
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  apu_song_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_WAIT} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_WAIT  = 2'b01;
  localparam logic [1:0] OP_LOOP  = 2'b10;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n, pc_inc;
  logic [7:0]            cnt, cnt_n;
  logic                  wr_valid, valid_n;
  logic [1:0]            wr_channel, ch_n;
  logic [3:0]            wr_reg, reg_n;
  logic [7:0]            wr_data, data_n;
  logic                  stop_pend, stop_pend_n;
  logic                  start_pend, start_pend_n;
  logic                  wd_trip;

  assign pc_inc = pc + 1'b1;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    cnt_n        = cnt;
    valid_n      = wr_valid;
    ch_n         = wr_channel;
    reg_n        = wr_reg;
    data_n       = wr_data;
    stop_pend_n  = stop_pend;
    start_pend_n = start_pend;
    case (state)
      S_IDLE: if (bus.start && !bus.stop) begin
        pc_n    = '0;
        state_n = S_FETCH;
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        case (bus.rom_data[15:14])
          OP_WRITE: begin
            ch_n    = bus.rom_data[13:12];
            reg_n   = bus.rom_data[11:8];
            data_n  = bus.rom_data[7:0];
            valid_n = 1'b1;
            state_n = S_WRITE;
          end
          OP_WAIT: begin
            pc_n = pc_inc;
            if (bus.rom_data[7:0] == 8'd0) state_n = S_FETCH;
            else begin
              cnt_n   = bus.rom_data[7:0];
              state_n = S_WAIT;
            end
          end
          OP_LOOP: begin
            pc_n    = bus.rom_data[ADDR_WIDTH-1:0];
            state_n = S_FETCH;
          end
          default: state_n = S_IDLE;
        endcase
        if (wd_trip) begin
          state_n = S_IDLE;
          valid_n = 1'b0;
          pc_n    = pc;
          cnt_n   = cnt;
        end
      end
      S_WRITE: begin
        // Control pulses arriving while a write is pending are parked until it is accepted
        if (bus.wr_ready) begin
          valid_n      = 1'b0;
          stop_pend_n  = 1'b0;
          start_pend_n = 1'b0;
          state_n      = S_FETCH;
          if (stop_pend || bus.stop)        state_n = S_IDLE;
          else if (start_pend || bus.start) pc_n = '0;
          else                              pc_n = pc_inc;
        end else begin
          if (bus.stop)  stop_pend_n  = 1'b1;
          if (bus.start) start_pend_n = 1'b1;
        end
      end
      S_WAIT: if (bus.frame_pulse) begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd1) state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
    if (state != S_IDLE && state != S_WRITE) begin
      if (bus.stop) begin
        state_n = S_IDLE;
        valid_n = 1'b0;
      end else if (bus.start) begin
        state_n = S_FETCH;
        pc_n    = '0;
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      cnt        <= '0;
      wr_valid   <= 1'b0;
      wr_channel <= '0;
      wr_reg     <= '0;
      wr_data    <= '0;
      stop_pend  <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      cnt        <= cnt_n;
      wr_valid   <= valid_n;
      wr_channel <= ch_n;
      wr_reg     <= reg_n;
      wr_data    <= data_n;
      stop_pend  <= stop_pend_n;
      start_pend <= start_pend_n;
    end
  end

`ifdef APU_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            error_q;

  // Trip on the decode that would be event number WATCHDOG_LIMIT since the last WAIT/IDLE
  assign wd_trip = (state == S_DECODE) && (int'(wd_cnt) >= WATCHDOG_LIMIT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == S_IDLE || state == S_WAIT) wd_cnt <= '0;
      else if (state == S_DECODE)             wd_cnt <= wd_cnt + 1'b1;
      if (bus.start && !bus.stop) error_q <= 1'b0;
      else if (wd_trip)           error_q <= 1'b1;
    end
  end

  assign bus.error = error_q;
`else
  assign wd_trip   = 1'b0;
  assign bus.error = 1'b0;
`endif

  assign bus.rom_addr   = pc;
  assign bus.wr_valid   = wr_valid;
  assign bus.wr_channel = wr_channel;
  assign bus.wr_reg     = wr_reg;
  assign bus.wr_data    = wr_data;
  assign bus.playing    = (state != S_IDLE);
endmodule

// File: tb/tb_apu_song_sequencer.sv
// Bench for apu_song_sequencer: random songs against an event-level player model,
// plus directed stop-deferral, reset, loop, restart and PC-wrap cases.
module tb_apu_song_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apu_song_sequencer_if #(.ADDR_WIDTH(10)) bus ();
  apu_song_sequencer #(.ADDR_WIDTH(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  logic [15:0] rom [1024];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  logic rnd_en = 1'b0, rnd_ready = 1'b0, rnd_pulse = 1'b0;
  logic dir_ready = 1'b0, dir_pulse = 1'b0;
  always @(negedge clk) begin
    rnd_ready = 1'($urandom_range(0, 1));
    rnd_pulse = ($urandom_range(0, 3) == 0);
  end
  assign bus.wr_ready    = rnd_en ? rnd_ready : dir_ready;
  assign bus.frame_pulse = rnd_en ? rnd_pulse : dir_pulse;

  int n_chk = 0, n_err = 0, hs_cnt = 0, m_nwr = 0;
  always @(posedge clk) if (bus.wr_valid && bus.wr_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected output view, driven by the player model and compared every negedge
  logic       chk_en = 1'b0;
  logic       exp_valid = 1'b0, exp_playing = 1'b0;
  logic [1:0] exp_ch = '0;
  logic [3:0] exp_reg = '0;
  logic [7:0] exp_data = '0;
  logic [9:0] exp_addr = '0;

  always @(negedge clk) if (chk_en) begin
    chk("valid", bus.wr_valid, exp_valid);
    chk("playing", bus.playing, exp_playing);
    chk("rom_addr", bus.rom_addr, exp_addr);
    if (exp_valid) begin
      chk("wr_channel", bus.wr_channel, exp_ch);
      chk("wr_reg", bus.wr_reg, exp_reg);
      chk("wr_data", bus.wr_data, exp_data);
    end
  end

  // Plays the song event by event: fetch+decode take two clocks, a write is held until
  // accepted, a WAIT n consumes n frame pulses seen while waiting, END returns to idle.
  task automatic model_play();
    logic [9:0]  pc;
    logic [15:0] w;
    int          cnt, guard;
    bit          done;
    pc = '0; done = 0; m_nwr = 0;
    exp_playing = 1'b1; exp_valid = 1'b0;
    while (!done) begin
      exp_addr = pc;
      @(posedge clk);
      w = rom[pc];
      @(posedge clk);
      case (w[15:14])
        2'b00: begin
          exp_valid = 1'b1; exp_ch = w[13:12]; exp_reg = w[11:8]; exp_data = w[7:0];
          guard = 0;
          do begin @(posedge clk); guard++; end while (!bus.wr_ready && guard < 2000);
          if (guard >= 2000) begin chk("hs_timeout", 1, 0); done = 1; end
          exp_valid = 1'b0; m_nwr++; pc = pc + 10'd1; exp_addr = pc;
        end
        2'b01: begin
          pc = pc + 10'd1; exp_addr = pc; cnt = int'(w[7:0]); guard = 0;
          while (cnt > 0 && guard < 2000) begin
            @(posedge clk); guard++;
            if (bus.frame_pulse) cnt--;
          end
          if (cnt > 0) begin chk("wait_timeout", 1, 0); done = 1; end
        end
        2'b10: pc = w[9:0];
        default: begin exp_playing = 1'b0; done = 1; end
      endcase
    end
  endtask

  task automatic run_song();
    int h0;
    h0 = hs_cnt;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    fork
      model_play();
      begin @(negedge clk); bus.start = 1'b0; end
    join
    repeat (4) @(negedge clk);
    chk("song_writes", hs_cnt - h0, m_nwr);
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  initial begin
    int  h0, len, r;
    bit  found;
    rst_n = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 16'hC000;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_error", bus.error, 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_no_writes", hs_cnt, 0);

    // Single write then END, ready tied high
    rom[0] = 16'h1A3C; rom[1] = 16'hC000; dir_ready = 1'b1;
    run_song();
    chk("single_write_cnt", m_nwr, 1);

    // WRITE, WAIT 3, WRITE with random ready and frame pulses
    rom[0] = 16'h0155; rom[1] = 16'h4003; rom[2] = 16'h2277; rom[3] = 16'hC000;
    rnd_en = 1'b1;
    run_song();
    chk("wait_song_cnt", m_nwr, 2);

    // Random songs: writes, short waits, forward loops, END
    for (int p = 0; p < 15; p++) begin
      len = $urandom_range(4, 12);
      for (int i = 0; i < len - 1; i++) begin
        r = $urandom_range(0, 9);
        if (r < 5)                       rom[i] = {2'b00, 14'($urandom)};
        else if (r < 8)                  rom[i] = {2'b01, 6'($urandom), 8'($urandom_range(0, 3))};
        else if (i + 2 <= len - 1)       rom[i] = 16'h8000 | 16'(i + 2);
        else                             rom[i] = {2'b00, 14'($urandom)};
      end
      rom[len - 1] = 16'hC000;
      run_song();
    end
    rnd_en = 1'b0; chk_en = 1'b0;

    // Stop while a write is stalled: write held stable, idle right after the handshake
    rom[0] = 16'h3155; rom[1] = 16'h3266; rom[2] = 16'hC000; dir_ready = 1'b0;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("stall_first_valid", bus.wr_valid, 1);
    chk("stall_first_ch", bus.wr_channel, 3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.stop = (c == 2);
      chk("stall_valid", bus.wr_valid, 1);
      chk("stall_reg", bus.wr_reg, 1);
      chk("stall_data", bus.wr_data, 8'h55);
    end
    bus.stop = 1'b0; dir_ready = 1'b1; h0 = hs_cnt;
    @(negedge clk);
    chk("stop_after_hs_playing", bus.playing, 0);
    chk("stop_after_hs_valid", bus.wr_valid, 0);
    repeat (6) @(negedge clk);
    chk("stop_one_hs_only", hs_cnt - h0, 1);

    // Async reset while a write is pending drops valid at once
    dir_ready = 1'b0;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("rstmid_valid_before", bus.wr_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_valid_dropped", bus.wr_valid, 0);
    chk("rstmid_playing", bus.playing, 0);
    @(negedge clk); rst_n = 1'b1;

    // Tight LOOP to self
    rom[0] = 16'h8000; dir_ready = 1'b1; h0 = hs_cnt;
    pulse_start();
    repeat (200) @(negedge clk);
    chk("loop_no_writes", hs_cnt - h0, 0);
`ifdef APU_SEQ_WATCHDOG_EN
    chk("loop_wd_error", bus.error, 1);
    chk("loop_wd_playing", bus.playing, 0);
`else
    chk("loop_playing", bus.playing, 1);
    chk("loop_error", bus.error, 0);
`endif
    @(negedge clk); bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_same_cycle", bus.playing, 0);

    // Restart from inside a WAIT
    rom[0] = 16'h4005; rom[1] = 16'hC000; dir_pulse = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("restart_wait_addr", bus.rom_addr, 1);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("restart_addr", bus.rom_addr, 0);
    chk("restart_playing", bus.playing, 1);
    bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    chk("restart_stopped", bus.playing, 0);

    // PC wrap: WAIT 0 everywhere, a write at the top address
    for (int i = 0; i < 1024; i++) rom[i] = 16'h4000;
    rom[1023] = 16'h2A5A; dir_ready = 1'b1;
    pulse_start();
    found = 0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (bus.wr_valid) found = 1;
    end
    chk("wrap_write_seen", found, 1);
    chk("wrap_write_addr", bus.rom_addr, 10'h3FF);
    chk("wrap_ch", bus.wr_channel, 2);
    chk("wrap_reg", bus.wr_reg, 4'hA);
    chk("wrap_data", bus.wr_data, 8'h5A);
    @(negedge clk);
    chk("wrap_next_addr", bus.rom_addr, 0);
    chk("wrap_valid_low", bus.wr_valid, 0);
    bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    chk("wrap_stopped", bus.playing, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
